// File: rtl/hazard_pkg.sv
// Shared types for the 5-stage pipeline hazard controller.
// FSM and forward-select encodings, plus the in-flight destination tracking entries.
package hazard_pkg;

  localparam int RW    = 5;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    FW_RF  = 2'b00,
    FW_EX  = 2'b01,
    FW_MEM = 2'b10,
    FW_WB  = 2'b11
  } fwd_t;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
  } dest_t;

  // The load flag only matters while the producer sits in EX, so MEM/WB carry dest_t alone.
  typedef struct packed {
    dest_t dest;
    logic  is_load;
  } track_t;

  function automatic logic dest_hit(dest_t e, logic use_op, logic [RW-1:0] rs);
    return use_op && (rs != '0) && e.valid && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// ID-stage hazard/forwarding bundle between the pipeline (master) and the hazard controller (slave).
// HAZARD_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface hazard_if;
  import hazard_pkg::*;

  logic [RW-1:0] id_ra;
  logic [RW-1:0] id_rb;
  logic [RW-1:0] id_rd;
  logic          id_use_a;
  logic          id_use_b;
  logic          id_rf_le;
  logic          id_l;
  logic          ex_j;
  logic          pc_le;
  logic          ifid_le;
  logic          cu_s;
  logic          if_s;
  fwd_t          a_s;
  fwd_t          b_s;
  state_t        state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ra, id_rb, id_rd, id_use_a, id_use_b, id_rf_le, id_l, ex_j,
    input  pc_le, ifid_le, cu_s, if_s, a_s, b_s, state, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_ra, id_rb, id_rd, id_use_a, id_use_b, id_rf_le, id_l, ex_j,
    output pc_le, ifid_le, cu_s, if_s, a_s, b_s, state, stall_cnt, flush_cnt
  );
`else
  modport master (
    output id_ra, id_rb, id_rd, id_use_a, id_use_b, id_rf_le, id_l, ex_j,
    input  pc_le, ifid_le, cu_s, if_s, a_s, b_s, state
  );
  modport slave (
    input  id_ra, id_rb, id_rd, id_use_a, id_use_b, id_rf_le, id_l, ex_j,
    output pc_le, ifid_le, cu_s, if_s, a_s, b_s, state
  );
`endif

endinterface

// File: rtl/fwd_select.sv
// Forward-source select for one ID operand: nearest in-flight producer wins (EX > MEM > WB).
module fwd_select
  import hazard_pkg::*;
(
  input  logic          use_op,
  input  logic [RW-1:0] rs,
  input  dest_t         ex_e,
  input  dest_t         mem_e,
  input  dest_t         wb_e,
  output fwd_t          sel
);

  always_comb begin
    sel = FW_RF;
    if (dest_hit(ex_e, use_op, rs))
      sel = FW_EX;
    else if (dest_hit(mem_e, use_op, rs))
      sel = FW_MEM;
    else if (dest_hit(wb_e, use_op, rs))
      sel = FW_WB;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: forwarding selects, single-bubble load-use stalls and branch squash.
// HAZARD_PERF_CNT_EN adds saturating STALL/FLUSH cycle counters.
module hazard_controller
  import hazard_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hif
);

  state_t state_q;
  track_t ex_q;
  dest_t  mem_q;
  dest_t  wb_q;
  fwd_t   a_sel;
  fwd_t   b_sel;
  logic   load_use;
  logic   squash;

  fwd_select u_fwd_a (
    .use_op (hif.id_use_a),
    .rs     (hif.id_ra),
    .ex_e   (ex_q.dest),
    .mem_e  (mem_q),
    .wb_e   (wb_q),
    .sel    (a_sel)
  );

  fwd_select u_fwd_b (
    .use_op (hif.id_use_b),
    .rs     (hif.id_rb),
    .ex_e   (ex_q.dest),
    .mem_e  (mem_q),
    .wb_e   (wb_q),
    .sel    (b_sel)
  );

  // A taken branch or a FLUSH cycle squashes ID anyway, so its load-use hazard is ignored.
  always_comb begin
    load_use = 1'b0;
    if (state_q != ST_FLUSH && !hif.ex_j && ex_q.is_load)
      load_use = (a_sel == FW_EX) || (b_sel == FW_EX);
    squash = hif.ex_j || load_use || (state_q == ST_FLUSH);
  end

  assign hif.pc_le   = ~load_use;
  assign hif.ifid_le = ~load_use;
  assign hif.cu_s    = squash;
  assign hif.if_s    = hif.ex_j;
  assign hif.a_s     = a_sel;
  assign hif.b_s     = b_sel;
  assign hif.state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      ex_q.dest.valid <= hif.id_rf_le && !squash && (hif.id_rd != '0);
      ex_q.dest.rd    <= hif.id_rd;
      ex_q.is_load    <= hif.id_l;
      mem_q           <= ex_q.dest;
      wb_q            <= mem_q;
      if (hif.ex_j)
        state_q <= ST_FLUSH;
      else if (state_q == ST_RUN && load_use)
        state_q <= ST_STALL;
      else
        state_q <= ST_RUN;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q == ST_STALL && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (state_q == ST_FLUSH && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;
`endif

endmodule
